aes_gcm_sequencer: RTL

- Front-end controller for the AES-GCM encryption pipeline.
- Accepts one GCM instance per start command (96-bit IV, AAD block count, plaintext block count).
- Pulls 128-bit blocks from an upstream valid/ready stream and emits one beat per cycle into pipeline stage 1: plain text, AAD, H seed, J0, counter block, instance size and new-instance flag.
- Inserts bubbles when upstream stalls, because the pipeline never stalls. Signals completion once the last beat has drained through the pipeline.

---
 rtl/aes_gcm_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/aes_gcm_sequencer.sv
// aes_gcm_sequencer: front-end controller for the AES-GCM pipeline.
// Captures one GCM instance per start command, emits a header beat and then
// one beat per accepted AAD/plaintext block, inserting bubbles on upstream
// stalls. A PIPE_DEPTH-deep shift register times the o_done pulse.
// Optional feature macro: AES_SEQ_OVERLAP_EN (accept a new start while the
// previous instance is still draining through the pipeline).
module aes_gcm_sequencer #(
  parameter int PIPE_DEPTH = 10,
  parameter int AAD_CNT_W  = 16,
  parameter int PT_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [0:95]          i_iv,
  input  logic [AAD_CNT_W-1:0] i_aad_blocks,
  input  logic [PT_CNT_W-1:0]  i_pt_blocks,
  input  logic                 i_blk_valid,
  input  logic [0:127]         i_blk_data,
  output logic                 o_blk_ready,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic                 o_new_instance,
  output logic [0:127]         o_plain_text,
  output logic [0:127]         o_aad,
  output logic [0:127]         o_h,
  output logic [0:127]         o_encrypted_j0,
  output logic [0:127]         o_encrypted_cb,
  output logic [0:127]         o_instance_size,
  output logic                 o_done
);

  typedef enum logic [2:0] {IDLE, HDR, AAD, PT, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [0:127]           j0_q, j0_d;
  logic [0:127]           cb_q, cb_d;
  logic [0:127]           size_q, size_d;
  logic [AAD_CNT_W-1:0]   aad_left_q, aad_left_d;
  logic [PT_CNT_W-1:0]    pt_left_q, pt_left_d;
  logic                   valid_q, valid_d;
  logic                   new_q, new_d;
  logic [0:127]           pt_out_q, pt_out_d;
  logic [0:127]           aad_out_q, aad_out_d;
  logic [0:127]           j0_out_q, j0_out_d;
  logic [0:127]           cb_out_q, cb_out_d;
  logic [0:127]           size_out_q, size_out_d;
  logic                   last_q, last_d;
  logic [PIPE_DEPTH-1:0]  drain_q, drain_d;
  logic                   start_ok;
  logic                   blk_fire;

  assign o_blk_ready     = (state_q == AAD) || (state_q == PT);
  assign blk_fire        = i_blk_valid && o_blk_ready;
  assign o_busy          = (state_q != IDLE) || last_q || (|drain_q);
  assign o_valid         = valid_q;
  assign o_new_instance  = new_q;
  assign o_plain_text    = pt_out_q;
  assign o_aad           = aad_out_q;
  assign o_h             = '0;
  assign o_encrypted_j0  = j0_out_q;
  assign o_encrypted_cb  = cb_out_q;
  assign o_instance_size = size_out_q;
  assign o_done          = drain_q[PIPE_DEPTH-1];

  // Next-state, next-beat and instance-capture logic
  always_comb begin
    state_d    = state_q;
    j0_d       = j0_q;
    cb_d       = cb_q;
    size_d     = size_q;
    aad_left_d = aad_left_q;
    pt_left_d  = pt_left_q;
    valid_d    = 1'b0;
    new_d      = 1'b0;
    pt_out_d   = '0;
    aad_out_d  = '0;
    j0_out_d   = '0;
    cb_out_d   = '0;
    size_out_d = '0;
    last_d     = 1'b0;
    drain_d    = {drain_q[PIPE_DEPTH-2:0], last_q};
    start_ok   = 1'b0;

    case (state_q)
      IDLE: start_ok = i_start;
      HDR: begin
        valid_d    = 1'b1;
        new_d      = 1'b1;
        j0_out_d   = j0_q;
        cb_out_d   = cb_q;
        size_out_d = size_q;
        if (aad_left_q != '0) begin
          state_d = AAD;
        end else if (pt_left_q != '0) begin
          state_d = PT;
        end else begin
          state_d = DRAIN;
          last_d  = 1'b1;
        end
      end
      AAD: begin
        if (blk_fire) begin
          valid_d    = 1'b1;
          aad_out_d  = i_blk_data;
          j0_out_d   = j0_q;
          cb_out_d   = cb_q;
          size_out_d = size_q;
          aad_left_d = aad_left_q - AAD_CNT_W'(1);
          if (aad_left_q == AAD_CNT_W'(1)) begin
            if (pt_left_q != '0) begin
              state_d = PT;
            end else begin
              state_d = DRAIN;
              last_d  = 1'b1;
            end
          end
        end
      end
      PT: begin
        if (blk_fire) begin
          valid_d          = 1'b1;
          pt_out_d         = i_blk_data;
          j0_out_d         = j0_q;
          cb_out_d         = cb_q;
          size_out_d       = size_q;
          cb_d[96:127]     = cb_q[96:127] + 32'd1;
          pt_left_d        = pt_left_q - PT_CNT_W'(1);
          if (pt_left_q == PT_CNT_W'(1)) begin
            state_d = DRAIN;
            last_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_d == '0) state_d = IDLE;
`ifdef AES_SEQ_OVERLAP_EN
        start_ok = i_start;
`else
        start_ok = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      state_d    = HDR;
      j0_d       = {i_iv, 32'h0000_0001};
      cb_d       = {i_iv, 32'h0000_0002};
      size_d     = {{(64-AAD_CNT_W-7){1'b0}}, i_aad_blocks, 7'd0,
                    {(64-PT_CNT_W-7){1'b0}}, i_pt_blocks, 7'd0};
      aad_left_d = i_aad_blocks;
      pt_left_d  = i_pt_blocks;
    end
  end

  // State, instance context, registered beat outputs and drain tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      j0_q       <= '0;
      cb_q       <= '0;
      size_q     <= '0;
      aad_left_q <= '0;
      pt_left_q  <= '0;
      valid_q    <= 1'b0;
      new_q      <= 1'b0;
      pt_out_q   <= '0;
      aad_out_q  <= '0;
      j0_out_q   <= '0;
      cb_out_q   <= '0;
      size_out_q <= '0;
      last_q     <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      j0_q       <= j0_d;
      cb_q       <= cb_d;
      size_q     <= size_d;
      aad_left_q <= aad_left_d;
      pt_left_q  <= pt_left_d;
      valid_q    <= valid_d;
      new_q      <= new_d;
      pt_out_q   <= pt_out_d;
      aad_out_q  <= aad_out_d;
      j0_out_q   <= j0_out_d;
      cb_out_q   <= cb_out_d;
      size_out_q <= size_out_d;
      last_q     <= last_d;
      drain_q    <= drain_d;
    end
  end

endmodule
